// File: rtl/bram_loader.sv
// Byte-stream to BRAM word loader: 4-byte LE word count, then N LE words written to addr 0..N-1.
// Optional trailing mod-256 data checksum byte when BRAM_LOADER_CHECKSUM_EN is defined.
module bram_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] di,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam logic [32:0] CAP   = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef BRAM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef BRAM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [31:0]         n_q, n_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   di_d;
  logic                rx_fire;
`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  assign rx_fire = rx_valid && rx_ready;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    addr_d  = addr;
    di_d    = di;
`ifdef BRAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HDR;
          n_d     = '0;
          bcnt_d  = '0;
          idx_d   = '0;
`ifdef BRAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_HDR: begin
        if (rx_fire) begin
          n_d    = {rx_data, n_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (n_d == 32'd0)             state_d = S_FIN;
            else if ({1'b0, n_d} > CAP)   state_d = S_ERROR;
            else                          state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          word_d = {rx_data, word_q[DATA_W-1:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef BRAM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = idx_q[ADDR_W-1:0];
            di_d    = word_d;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if (32'(idx_q) + 32'd1 == n_q) state_d = S_FIN;
        else                           state_d = S_DATA;
      end
`ifdef BRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_fire) state_d = (rx_data == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs follow the next state)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      word_q   <= '0;
      bcnt_q   <= '0;
      idx_q    <= '0;
      rx_ready <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      di       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef BRAM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      idx_q    <= idx_d;
      addr     <= addr_d;
      di       <= di_d;
      we       <= (state_d == S_WRITE);
      done     <= (state_d == S_DONE);
      error    <= (state_d == S_ERROR);
      busy     <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WRITE)
`ifdef BRAM_LOADER_CHECKSUM_EN
                  || (state_d == S_CSUM)
`endif
                  ;
      rx_ready <= (state_d == S_HDR) || (state_d == S_DATA)
`ifdef BRAM_LOADER_CHECKSUM_EN
                  || (state_d == S_CSUM)
`endif
                  ;
`ifdef BRAM_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

endmodule

// File: doc/bram_loader.md
Name: bram_loader

Overview:
- Upstream feeder for the single-port instruction/data BRAM: takes a byte stream from the host link and writes it as 32-bit words into the BRAM write port.
- Stream format: 4-byte little-endian word count N, then N*4 data bytes, each word little-endian.
- Holds the core off the memory port while loading and signals completion or error.

Parameters:
- ADDR_W, 10, BRAM word-address width; capacity = 2**ADDR_W words.
- DATA_W, 32, BRAM word width; fixed at 32 (4 bytes per word).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERROR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid; byte accepted when rx_valid && rx_ready.
- rx_ready  out  1  loader can accept a byte.
- we  out  1  BRAM write enable, one-cycle pulse per word.
- addr  out  ADDR_W  BRAM word address.
- di  out  DATA_W  BRAM write data.
- busy  out  1  load in progress; core must not drive the BRAM while high.
- done  out  1  last load completed without error; level output.
- error  out  1  last load aborted; level output.

Behaviour:
- Reset: state IDLE; rx_ready=0, we=0, addr=0, di=0, busy=0, done=0, error=0; byte, word and header counters cleared.
- States: IDLE, HDR, DATA, WRITE, CSUM (only with the optional feature), DONE, ERROR.
- IDLE/DONE/ERROR + start -> HDR. Same cycle: clear done, clear error, word index to 0, byte counter to 0, busy=1.
- HDR: rx_ready=1. Each accepted byte shifts into N, first byte into N[7:0]. After the 4th byte:
  - N==0 -> DONE (or CSUM if enabled).
  - N > 2**ADDR_W -> ERROR.
  - otherwise -> DATA.
  - N is a 32-bit compare; no truncation before the check.
- DATA: rx_ready=1. Byte k of a word (k=0..3) goes to word[8k+7:8k]. On the 4th byte -> WRITE.
- WRITE: exactly one cycle.
  - we=1, addr=word index, di=assembled word; rx_ready=0.
  - Next cycle, word index+1.
  - If the word index was N-1 -> DONE (or CSUM); else -> DATA.
- Write latency: 4th byte of a word accepted in cycle t -> we=1 in cycle t+1. Back-to-back rx_valid sustains 4 bytes per 5 cycles.
- addr holds its last value when we=0. Words go to addresses 0..N-1; no wrap-around, because N is bounded by the capacity check.
- DONE: busy=0, done=1, rx_ready=0, we=0.
- ERROR: busy=0, error=1, rx_ready=0. Remaining stream bytes are not consumed; the host resets or issues a new start.
- start while busy=1: ignored.
- rx_valid while rx_ready=0: byte not taken; the upstream holds it.
- Reset asserted mid-load: immediate return to reset values. BRAM contents already written are left as-is; done stays 0.
- done and error are never both 1.

Optional Feature:
- Macro: BRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all data bytes, not header bytes, is kept; cleared on start.
  - After the final word, or directly after the header when N==0, state CSUM accepts one more byte (rx_ready=1).
  - Byte equals the sum -> DONE; otherwise -> ERROR.
  - BRAM writes are not undone.
- Undefined: no CSUM state, no sum logic; the final WRITE (or N==0 header) goes straight to DONE.

Test Plan:
- N=2, bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 -> two writes: addr 0, di 0x00000013; then addr 1, di 0x00100093. done=1, busy=0, error=0.
- N=0 (00 00 00 00) -> no we pulse, done=1 (with checksum on: send 00 -> done=1).
- N=0x00000401 with ADDR_W=10 -> error=1 after the 4th header byte, no writes, rx_ready=0.
- N=1024, continuous rx_valid -> 1024 writes at addr 0..1023, each we one cycle; rx_ready low in every WRITE cycle; 5 cycles per word; done=1.
- rstn pulsed low after 6 data bytes of an N=2 load -> all outputs at reset values immediately; a new start and full stream then loads correctly.
- Checksum on, N=1, data 01 02 03 04: checksum 0A -> done=1; checksum 0B -> error=1, and addr 0 still holds 0x04030201.
